// File: rtl/lc3b_ctrl_pipe.sv
// Elastic DEPTH-stage pipeline carrying the decoded LC-3b control word from decode to writeback.
// Every stage can be stalled or flushed on its own, and empty stages are refilled from behind.
module lc3b_ctrl_pipe #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_word,
  input  logic [DEPTH-1:0]       stall_i,
  input  logic [DEPTH-1:0]       flush_i,
  output logic [DEPTH-1:0]       stage_valid_o,
  output logic [DEPTH*WIDTH-1:0] stage_word_o,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_word,
  output logic [CW-1:0]          occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] room;
  logic [DEPTH-1:0] incoming;
  logic [DEPTH-1:0] kill;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] src    [DEPTH];
  logic [CW-1:0]    occ_next;

  // Room ripples from the output back toward stage 0; flush deliberately never frees room.
  always_comb begin
    adv  = '0;
    room = '0;
    adv[DEPTH-1]  = v[DEPTH-1] & ~flush_i[DEPTH-1] & ~stall_i[DEPTH-1] & out_ready;
    room[DEPTH-1] = ~v[DEPTH-1] | adv[DEPTH-1];
    for (int k = DEPTH-2; k >= 0; k--) begin
      adv[k]  = v[k] & ~flush_i[k] & ~stall_i[k] & room[k+1];
      room[k] = ~v[k] | adv[k];
    end
  end

  always_comb begin
    incoming    = '0;
    incoming[0] = in_valid & room[0];
    src[0]      = in_word;
    for (int k = 1; k < DEPTH; k++) begin
      incoming[k] = adv[k-1];
      src[k]      = word_q[k-1];
    end
    kill = v & flush_i;
  end

  always_comb begin
    int n;
    n = int'(occupancy) + (incoming[0] ? 1 : 0) - (adv[DEPTH-1] ? 1 : 0) - $countones(kill);
    occ_next = CW'(n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v         <= '0;
      occupancy <= '0;
      for (int k = 0; k < DEPTH; k++) word_q[k] <= '0;
    end else begin
      occupancy <= occ_next;
      for (int k = 0; k < DEPTH; k++) begin
        if (incoming[k]) begin
          v[k]      <= 1'b1;
          word_q[k] <= src[k];
        end else if (adv[k] | kill[k]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    stage_word_o = '0;
    for (int k = 0; k < DEPTH; k++) stage_word_o[k*WIDTH +: WIDTH] = word_q[k];
  end

  assign in_ready      = room[0];
  assign out_valid     = v[DEPTH-1] & ~flush_i[DEPTH-1] & ~stall_i[DEPTH-1];
  assign out_word      = word_q[DEPTH-1];
  assign stage_valid_o = v;

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// Self-checking bench for lc3b_ctrl_pipe: directed cases plus a random run against
// a stage model and an in-order scoreboard of accepted words.
module tb_lc3b_ctrl_pipe;
  localparam int WIDTH = 17;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic                   clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0]       in_word, out_word;
  logic [DEPTH-1:0]       stall_i, flush_i, stage_valid_o;
  logic [DEPTH*WIDTH-1:0] stage_word_o;
  logic [CW-1:0]          occupancy;

  int assertions = 0;
  int failures   = 0;
  int delivered  = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [DEPTH-1:0] mv;
  logic [WIDTH-1:0] mw [DEPTH];
  logic             s_ir, s_ov, s_acc;
  logic [WIDTH-1:0] s_ow;

  lc3b_ctrl_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .stall_i(stall_i), .flush_i(flush_i), .stage_valid_o(stage_valid_o),
    .stage_word_o(stage_word_o), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mv = '0;
    for (int k = 0; k < DEPTH; k++) mw[k] = '0;
    sb_q.delete();
  endtask

  // Drives one cycle from a negedge, checks against the stage model just before the
  // rising edge, updates scoreboard and model, and returns at the following negedge.
  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] iw,
                               input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl,
                               input logic ordy);
    logic [DEPTH-1:0] madv, mroom, nv;
    logic [WIDTH-1:0] nw [DEPTH];
    logic [WIDTH-1:0] exp;
    int idx;
    in_valid = iv; in_word = iw; stall_i = st; flush_i = fl; out_ready = ordy;
    #4;
    madv = '0; mroom = '0;
    madv[DEPTH-1]  = mv[DEPTH-1] & ~fl[DEPTH-1] & ~st[DEPTH-1] & ordy;
    mroom[DEPTH-1] = ~mv[DEPTH-1] | madv[DEPTH-1];
    for (int k = DEPTH-2; k >= 0; k--) begin
      madv[k]  = mv[k] & ~fl[k] & ~st[k] & mroom[k+1];
      mroom[k] = ~mv[k] | madv[k];
    end
    s_ir = in_ready; s_ov = out_valid; s_ow = out_word; s_acc = iv & in_ready;
    checkOutput("valid_bits", stage_valid_o, mv);
    checkOutput("occ_popcount", occupancy, $countones(stage_valid_o));
    checkOutput("in_ready", in_ready, mroom[0]);
    checkOutput("out_valid", out_valid, mv[DEPTH-1] & ~fl[DEPTH-1] & ~st[DEPTH-1]);
    for (int k = 0; k < DEPTH; k++)
      if (mv[k]) checkOutput($sformatf("stage%0d_word", k), stage_word_o[k*WIDTH +: WIDTH], mw[k]);
    for (int k = 0; k < DEPTH; k++) begin
      if (mv[k] & fl[k]) begin
        idx = -1;
        foreach (sb_q[i]) if (idx < 0 && sb_q[i] == mw[k]) idx = i;
        checkOutput("flushed_in_sb", idx >= 0, 1);
        if (idx >= 0) sb_q.delete(idx);
      end
    end
    if (out_valid & ordy) begin
      delivered++;
      checkOutput("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checkOutput("out_word", out_word, exp);
      end
    end
    if (iv & in_ready) sb_q.push_back(iw);
    nv = mv;
    for (int k = 0; k < DEPTH; k++) nw[k] = mw[k];
    if (iv & mroom[0]) begin
      nv[0] = 1'b1; nw[0] = iw;
    end else if (madv[0] | (mv[0] & fl[0])) nv[0] = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (madv[k-1]) begin
        nv[k] = 1'b1; nw[k] = mw[k-1];
      end else if (madv[k] | (mv[k] & fl[k])) nv[k] = 1'b0;
    end
    mv = nv;
    for (int k = 0; k < DEPTH; k++) mw[k] = nw[k];
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int peak, acc, n, first_ov;
    logic [DEPTH-1:0] st, fl;
    rst = 1'b0; in_valid = 1'b0; in_word = '0; stall_i = '0; flush_i = '0; out_ready = 1'b0;
    modelReset();
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_valid", stage_valid_o, 0);
    checkOutput("rst_occ", occupancy, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_word", out_word, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] streaming");
    peak = 0;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c < 3, WIDTH'(c + 1), '0, '0, 1'b1);
      checkOutput("stream_ov", s_ov, (c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) checkOutput("stream_word", s_ow, c - 3);
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    checkOutput("stream_peak", peak, 3);
    checkOutput("stream_final_occ", occupancy, 0);

    $display("[TB] backpressure");
    acc = 0; delivered = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, WIDTH'(32'h10 + acc), '0, '0, 1'b0);
      if (s_acc) acc++;
    end
    checkOutput("bp_accepts", acc, 4);
    checkOutput("bp_in_ready", s_ir, 0);
    checkOutput("bp_occ", occupancy, 4);
    for (int c = 0; c < 30 && delivered < 6; c++) begin
      applyStimulus(acc < 6, WIDTH'(32'h10 + acc), '0, '0, 1'b1);
      if (s_acc) acc++;
    end
    checkOutput("bp_delivered", delivered, 6);
    checkOutput("bp_sb_empty", sb_q.size(), 0);

    $display("[TB] bubble collapse");
    applyStimulus(1'b1, 17'h0AAAA, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    applyStimulus(1'b1, 17'h0CCCC, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    checkOutput("bub_setup", stage_valid_o, 4'b1010);
    applyStimulus(1'b0, '0, 4'b1000, '0, 1'b0);
    checkOutput("bub_in_ready", s_ir, 1);
    checkOutput("bub_valid", stage_valid_o, 4'b1100);
    checkOutput("bub_s2", stage_word_o[2*WIDTH +: WIDTH], 17'h0CCCC);
    checkOutput("bub_s3", stage_word_o[3*WIDTH +: WIDTH], 17'h0AAAA);
    delivered = 0;
    for (int c = 0; c < 20 && delivered < 2; c++) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("bub_delivered", delivered, 2);

    $display("[TB] flush");
    applyStimulus(1'b1, 17'h01111, '0, '0, 1'b0);
    applyStimulus(1'b1, 17'h02222, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    checkOutput("flush_setup", stage_valid_o, 4'b0110);
    checkOutput("flush_setup_occ", occupancy, 2);
    applyStimulus(1'b0, '0, 4'b0100, 4'b0110, 1'b0);
    checkOutput("flush_valid", stage_valid_o, 0);
    checkOutput("flush_occ", occupancy, 0);
    checkOutput("flush_sb_empty", sb_q.size(), 0);
    delivered = 0;
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("flush_no_output", delivered, 0);

    $display("[TB] async reset");
    applyStimulus(1'b1, 17'h03333, '0, '0, 1'b1);
    applyStimulus(1'b1, 17'h04444, '0, '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", stage_valid_o, 0);
    checkOutput("arst_occ", occupancy, 0);
    checkOutput("arst_in_ready", in_ready, 1);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    delivered = 0; first_ov = -1;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c == 0, 17'h05555, '0, '0, 1'b1);
      if (s_ov && first_ov < 0) first_ov = c;
    end
    checkOutput("arst_latency", first_ov, 4);
    checkOutput("arst_delivered", delivered, 1);

    $display("[TB] random regression");
    n = 0;
    for (int c = 0; c < 300; c++) begin
      for (int b = 0; b < DEPTH; b++) begin
        st[b] = ($urandom_range(0, 9) == 0);
        fl[b] = ($urandom_range(0, 19) == 0);
      end
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'(32'h100 + n), st, fl,
                    $urandom_range(0, 9) < 7);
      if (s_acc) n++;
    end
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("rand_sb_empty", sb_q.size(), 0);
    checkOutput("rand_final_occ", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/lc3b_ctrl_pipe.md
Name: lc3b_ctrl_pipe

Overview:
- Parametrised elastic pipeline that carries a decoded control word (opcode, load_cc, is_br, aluop, mux selects, regfile/memory enables) from decode to writeback.
- Replaces hand-written per-stage control registers with one DEPTH-stage instance.
- Adds per-stage stall, per-stage flush, bubble collapsing, a valid/ready handshake at both ends, and an occupancy count.

Parameters:
- WIDTH, 17, payload bits per stage (default = packed control word width).
- DEPTH, 4, number of register stages; must be >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream offers in_word.
- in_ready  out  1  stage 0 can accept this cycle.
- in_word  in  WIDTH  control word from decode.
- stall_i  in  DEPTH  bit k: hold stage k in place.
- flush_i  in  DEPTH  bit k: kill the entry currently held in stage k.
- stage_valid_o  out  DEPTH  per-stage valid bits.
- stage_word_o  out  DEPTH*WIDTH  per-stage payloads; stage k at bits [k*WIDTH +: WIDTH].
- out_valid  out  1  last stage offers out_word.
- out_ready  in  1  downstream accepts.
- out_word  out  WIDTH  payload of stage DEPTH-1.
- occupancy  out  CW  number of valid stages.

Behaviour:
- Reset (async, rst=1): all valid bits 0, all payload registers 0, occupancy 0. Consequently in_ready=1, out_valid=0, out_word=0. Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Define v[k] as the registered valid bit of stage k.
- Advance, stage k<DEPTH-1: adv[k] = v[k] & ~flush_i[k] & ~stall_i[k] & room[k+1].
- Advance, last stage: adv[DEPTH-1] = v[DEPTH-1] & ~flush_i[DEPTH-1] & ~stall_i[DEPTH-1] & out_ready.
- Room: room[k] = ~v[k] | adv[k]. Flush does not contribute to room; there is no combinational path from flush_i to in_ready.
- in_ready = room[0]. Stage 0 accepts when in_valid & in_ready.
- out_valid = v[DEPTH-1] & ~flush_i[DEPTH-1] & ~stall_i[DEPTH-1]. out_word = payload of stage DEPTH-1. A transfer occurs when out_valid & out_ready.
- Next-state rule for stage k, where the incoming source is stage k-1 (adv[k-1]) or the input port for k=0 (in_valid & in_ready):
  - incoming: load source payload, v[k] <= 1;
  - else if adv[k] or (v[k] & flush_i[k]): v[k] <= 0, payload unchanged;
  - else: hold.
- Flush and stall on the same stage: flush wins; the entry is dropped.
- Because room excludes flush, a flushed stage cannot receive a new entry in the same cycle.
- Bubble collapsing: an empty stage k is filled from stage k-1 even when stage k+1 is stalled. A stall holds only the stalled stage and, via room, the stages behind it.
- Latency: an entry presented with all stages empty and no stalls reaches out_valid DEPTH cycles after acceptance. Full throughput is 1 word/cycle.
- Full: all v=1 and the last stage is blocked -> in_ready=0. Empty: out_valid=0.
- Occupancy: the registered count of set v bits, recomputed as +accept, -out transfer, -flushed valid entries.
  - It must always equal popcount(stage_valid_o).
  - Range is 0..DEPTH; it never wraps.
- Payloads of invalid stages are don't-care for downstream. The bench compares payload only where valid=1.

Test Plan:
- Streaming, DEPTH=4, WIDTH=17, no stalls, out_ready=1: inject 0x00001,0x00002,0x00003 on consecutive cycles -> out_word shows 0x00001,0x00002,0x00003 on cycles 4,5,6 after the first accept; occupancy peaks at 3 and returns to 0.
- Backpressure: out_ready=0 with 6 offered words -> in_ready drops after 4 accepts, occupancy=4; raise out_ready -> 4 words drain in order, then remaining 2 follow with no loss or duplication.
- Bubble collapse: words A in stage 3 and C in stage 1, stage 2 empty, stall_i=4'b1000 -> next cycle C in stage 2, A held in stage 3, in_ready=1.
- Flush: stages 1 and 2 valid, flush_i=4'b0110 pulsed one cycle along with stall_i[2]=1 -> both stages invalid, occupancy drops by 2, neither word appears at out_word.
- Async reset: assert rst mid-stream between clock edges -> stage_valid_o=0, occupancy=0, in_ready=1 immediately; release rst -> the next accepted word flows normally.
- Random regression: random stall/flush/in_valid/out_ready against a scoreboard -> in-order delivery of non-flushed words, occupancy==popcount(stage_valid_o) every cycle.
